flow_control_loop_pipe_seq_init: RTL and testbench

//  Handshake adapter between an ap_start/ap_done/ap_ready block interface and a pipelined loop body.
//  - Forwards start into the pipeline.
//  - Generates a one-shot loop-init flag so the loop body resets its induction variable.
//  - Converts loop-exit events into block-level ready/done.
//  - Instantiated once per pipelined loop kernel, e.g. an 8-iteration vector-subtract row loop.

---
 rtl/flow_control_loop_pipe_seq_init_if.sv | 49 ++++
 rtl/flow_control_loop_pipe_seq_init.sv | 53 +++++
 tb/tb_flow_control_loop_pipe_seq_init.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/flow_control_loop_pipe_seq_init_if.sv
// Block/loop handshake bundle for flow_control_loop_pipe_seq_init.
// LOOP_CONTINUE_EN adds the ap_continue wire.
interface flow_control_loop_pipe_seq_init_if;
    logic ap_start;
    logic ap_ready;
    logic ap_done;
    logic ap_start_int;
    logic ap_loop_init;
    logic ap_ready_int;
    logic ap_loop_exit_ready;
    logic ap_loop_exit_done;
    logic ap_continue_int;
    logic ap_done_int;
`ifdef LOOP_CONTINUE_EN
    logic ap_continue;
`endif

    modport master (
`ifdef LOOP_CONTINUE_EN
        output ap_continue,
`endif
        output ap_start,
        output ap_ready_int,
        output ap_loop_exit_ready,
        output ap_loop_exit_done,
        output ap_done_int,
        input  ap_ready,
        input  ap_done,
        input  ap_start_int,
        input  ap_loop_init,
        input  ap_continue_int
    );

    modport slave (
`ifdef LOOP_CONTINUE_EN
        input  ap_continue,
`endif
        input  ap_start,
        input  ap_ready_int,
        input  ap_loop_exit_ready,
        input  ap_loop_exit_done,
        input  ap_done_int,
        output ap_ready,
        output ap_done,
        output ap_start_int,
        output ap_loop_init,
        output ap_continue_int
    );
endinterface

// File: rtl/flow_control_loop_pipe_seq_init.sv
// Block-level start/ready/done adapter around a pipelined loop body.
// LOOP_CONTINUE_EN: hold ap_done until the parent asserts ap_continue.
module flow_control_loop_pipe_seq_init (
    input logic ap_clk,
    input logic ap_rst_n,
    flow_control_loop_pipe_seq_init_if.slave bus
);

    logic loop_init_reg;
    logic loop_init_nxt;
    logic done_cache;
    logic done_cache_nxt;
    logic continue_w;

`ifdef LOOP_CONTINUE_EN
    assign continue_w = bus.ap_continue;
`else
    assign continue_w = 1'b1;
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            loop_init_reg <= 1'b1;
            done_cache    <= 1'b0;
        end else begin
            loop_init_reg <= loop_init_nxt;
            done_cache    <= done_cache_nxt;
        end
    end

    // Exit beats iteration accept so the next run restarts at index 0
    always_comb begin
        loop_init_nxt  = loop_init_reg;
        done_cache_nxt = done_cache;
        if (bus.ap_loop_exit_done)
            loop_init_nxt = 1'b1;
        else if (bus.ap_ready_int)
            loop_init_nxt = 1'b0;
        if (bus.ap_loop_exit_done)
            done_cache_nxt = 1'b1;
        else if (continue_w)
            done_cache_nxt = 1'b0;
    end

    always_comb begin
        bus.ap_start_int    = bus.ap_start;
        bus.ap_ready        = bus.ap_loop_exit_ready;
        bus.ap_loop_init    = loop_init_reg & bus.ap_start;
        bus.ap_done         = bus.ap_loop_exit_done | done_cache;
        bus.ap_continue_int = continue_w;
    end

endmodule

// File: tb/tb_flow_control_loop_pipe_seq_init.sv
// Scoreboard bench for flow_control_loop_pipe_seq_init.
// Expected outputs derive from event-time bookkeeping of exits/accepts.
module tb_flow_control_loop_pipe_seq_init;

    logic clk;
    logic rst_n;

    flow_control_loop_pipe_seq_init_if bus ();

    flow_control_loop_pipe_seq_init dut (
        .ap_clk  (clk),
        .ap_rst_n(rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rdy;
        logic done;
        logic sint;
        logic init;
        logic cint;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Model: event cycle numbers; "armed" means the latest exit/reset
    // is no older than the latest accepted iteration.
    int cyc      = 0;
    int init_evt = 0;
    int rdy_evt  = -1;
    int exit_evt = -1;
    int cont_evt = -1;

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %b want %b", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ap_ready", bus.ap_ready, e.rdy);
            chk("ap_done", bus.ap_done, e.done);
            chk("ap_start_int", bus.ap_start_int, e.sint);
            chk("ap_loop_init", bus.ap_loop_init, e.init);
            chk("ap_continue_int", bus.ap_continue_int, e.cint);
        end
    end

    task automatic step(input logic s, input logic r, input logic xr,
                        input logic xd, input logic c, input bit rp);
        exp_t e;
        logic ce;
        @(posedge clk);
        #1;
        cyc++;
        bus.ap_start           = s;
        bus.ap_ready_int       = r;
        bus.ap_loop_exit_ready = xr;
        bus.ap_loop_exit_done  = xd;
        bus.ap_done_int        = 1'($urandom_range(0, 1));
`ifdef LOOP_CONTINUE_EN
        bus.ap_continue = c;
        ce = c;
`else
        ce = 1'b1;
`endif
        if (rp) begin
            init_evt = cyc - 1;
            exit_evt = -1;
        end
        e.rdy  = xr;
        e.sint = s;
        e.cint = ce;
        e.init = s & (init_evt >= rdy_evt);
        e.done = xd | (exit_evt >= 0 && cont_evt <= exit_evt);
        q.push_back(e);
        if (xd) begin
            init_evt = cyc;
            exit_evt = cyc;
        end
        if (r)
            rdy_evt = cyc;
        if (ce)
            cont_evt = cyc;
        if (rp) begin
            #1 rst_n = 1'b0;
            #4 rst_n = 1'b1;
        end
    endtask

    task automatic run8(input logic c);
        for (int i = 0; i < 8; i++)
            step(1, 1, 0, 0, c, 0);
        step(1, 0, 1, 0, c, 0);
        step(1, 0, 0, 1, c, 0);
    endtask

    initial begin
        bus.ap_start           = 1'b0;
        bus.ap_ready_int       = 1'b0;
        bus.ap_loop_exit_ready = 1'b0;
        bus.ap_loop_exit_done  = 1'b0;
        bus.ap_done_int        = 1'b0;
`ifdef LOOP_CONTINUE_EN
        bus.ap_continue = 1'b0;
`endif
        rst_n = 1'b0;
        #12 rst_n = 1'b1;

        // idle after reset
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        // two back-to-back 8-iteration runs, start held across exit
        run8(1);
        run8(1);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        // done held while continue is low
        step(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++)
            step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        // exit and accept in the same cycle
        step(1, 1, 0, 1, 1, 0);
        step(1, 1, 0, 0, 1, 0);
        // reset pulse mid-loop between edges
        step(1, 1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 1);
        step(1, 1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        step(1, 1, 0, 0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 2) == 0),
                 $urandom_range(0, 49) == 0);
        end

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain left %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
